// File: rtl/bus_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arb_pkg
//  Description : Shared types and constants for the round-robin bus arbiter:
//                FSM state encoding, client direction codes, reset values.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_arb_pkg;

  // Arbiter FSM state encoding
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  // Client direction encoding carried on wr_ni
  localparam logic WR_NI_READ  = 1'b1;
  localparam logic WR_NI_WRITE = 1'b0;

  // Reset values of the registered outputs
  localparam logic RST_RQ    = 1'b0;
  localparam logic RST_WR_NI = WR_NI_READ;
  localparam logic RST_BUSY  = 1'b0;

endpackage : bus_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin selector. Searches the request
//                vector starting one past the last granted index, wrapping
//                around, and returns the first requester found.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [IDX_W-1:0] winner_o,
  output logic             valid_o
);

  logic [IDX_W-1:0] w_idx;

  // Scan from the farthest offset down to the nearest so the closest
  // requester after last_i is the one left standing.
  always_comb begin
    w_idx    = '0;
    winner_o = '0;
    valid_o  = 1'b0;
    for (int k = N; k >= 1; k--) begin
      w_idx = IDX_W'((int'(last_i) + k) % N);
      if (req_i[w_idx]) begin
        winner_o = w_idx;
        valid_o  = 1'b1;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter
//  Description : Round-robin arbiter sharing one client bus among N_MASTERS
//                masters. Drives the client rq/ack four-phase handshake,
//                returns read data with a one-cycle acknowledge, and aborts
//                with an error flag when the client never acknowledges.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int N_MASTERS  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [N_MASTERS-1:0]             m_rq,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0]  m_addr,
  input  logic [N_MASTERS-1:0]             m_wr_ni,
  input  logic [N_MASTERS*DATA_WIDTH-1:0]  m_dataW,
  output logic [N_MASTERS-1:0]             m_ack,
  output logic [N_MASTERS-1:0]             m_err,
  output logic [DATA_WIDTH-1:0]            m_dataR,
  output logic [ADDR_WIDTH-1:0]            address,
  output logic                             rq,
  input  logic                             ack,
  output logic                             wr_ni,
  output logic [DATA_WIDTH-1:0]            dataW,
  input  logic [DATA_WIDTH-1:0]            dataR,
  output logic                             busy,
  output logic [$clog2(N_MASTERS)-1:0]     grant_id
);

  localparam int IDX_W = $clog2(N_MASTERS);
  localparam int TMR_W = $clog2(TIMEOUT);

  arb_state_e             state_q;
  logic [IDX_W-1:0]       grant_q;
  logic [IDX_W-1:0]       last_q;
  logic [TMR_W-1:0]       timer_q;
  logic                   rq_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   wr_ni_q;
  logic [DATA_WIDTH-1:0]  dataw_q;
  logic [DATA_WIDTH-1:0]  m_datar_q;
  logic [N_MASTERS-1:0]   m_ack_q;
  logic [N_MASTERS-1:0]   m_err_q;

  logic [IDX_W-1:0]       w_pick;
  logic                   w_valid;
  logic [ADDR_WIDTH-1:0]  w_addr  [N_MASTERS];
  logic [DATA_WIDTH-1:0]  w_wdata [N_MASTERS];

  // Split the flat master buses into per-master lanes
  for (genvar i = 0; i < N_MASTERS; i++) begin : g_unpack
    assign w_addr[i]  = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata[i] = m_dataW[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i    (m_rq),
    .last_i   (last_q),
    .winner_o (w_pick),
    .valid_o  (w_valid)
  );

  // Arbiter FSM with timeout timer and all registered outputs.
  // Completion pulses default low every cycle so they last exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= IDX_W'(N_MASTERS - 1);
      timer_q   <= '0;
      rq_q      <= RST_RQ;
      addr_q    <= '0;
      wr_ni_q   <= RST_WR_NI;
      dataw_q   <= '0;
      m_datar_q <= '0;
      m_ack_q   <= '0;
      m_err_q   <= '0;
    end else begin
      m_ack_q <= '0;
      m_err_q <= '0;
      case (state_q)
        IDLE: begin
          if (w_valid) begin
            grant_q <= w_pick;
            addr_q  <= w_addr[w_pick];
            wr_ni_q <= m_wr_ni[w_pick];
            dataw_q <= w_wdata[w_pick];
            rq_q    <= 1'b1;
            timer_q <= '0;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (ack) begin
            m_datar_q        <= dataR;
            m_ack_q[grant_q] <= 1'b1;
            rq_q             <= 1'b0;
            last_q           <= grant_q;
            state_q          <= RELEASE;
          end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
            // Client is unresponsive: abort, keep previous read data
            m_ack_q[grant_q] <= 1'b1;
            m_err_q[grant_q] <= 1'b1;
            rq_q             <= 1'b0;
            last_q           <= grant_q;
            state_q          <= RELEASE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        RELEASE: begin
          // Complete the four-phase handshake before the next grant
          if (!ack) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = (state_q != IDLE) ? 1'b1 : RST_BUSY;
  assign grant_id = grant_q;
  assign rq       = rq_q;
  assign address  = addr_q;
  assign wr_ni    = wr_ni_q;
  assign dataW    = dataw_q;
  assign m_dataR  = m_datar_q;
  assign m_ack    = m_ack_q;
  assign m_err    = m_err_q;

endmodule : bus_arbiter
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter
//  Description : Self-checking bench for bus_arbiter. Directed scenarios plus
//                randomized transactions checked against a behavioural model
//                of round-robin arbitration and the client handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;
  import bus_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int TO = 16;
  localparam int IW = $clog2(N);

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    m_rq;
  logic [N*AW-1:0] m_addr;
  logic [N-1:0]    m_wr_ni;
  logic [N*DW-1:0] m_dataW;
  logic [N-1:0]    m_ack;
  logic [N-1:0]    m_err;
  logic [DW-1:0]   m_dataR;
  logic [AW-1:0]   address;
  logic            rq;
  logic            ack;
  logic            wr_ni;
  logic [DW-1:0]   dataW;
  logic [DW-1:0]   dataR;
  logic            busy;
  logic [IW-1:0]   grant_id;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  int            model_last;
  logic [DW-1:0] model_dataR;
  logic [N-1:0]  pend;
  logic [AW-1:0] ma  [N];
  logic          mdir[N];
  logic [DW-1:0] mdw [N];
  logic [N-1:0]  nr;

  always #5 clk = ~clk;

  bus_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .N_MASTERS  (N),
    .TIMEOUT    (TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .m_rq     (m_rq),
    .m_addr   (m_addr),
    .m_wr_ni  (m_wr_ni),
    .m_dataW  (m_dataW),
    .m_ack    (m_ack),
    .m_err    (m_err),
    .m_dataR  (m_dataR),
    .address  (address),
    .rq       (rq),
    .ack      (ack),
    .wr_ni    (wr_ni),
    .dataW    (dataW),
    .dataR    (dataR),
    .busy     (busy),
    .grant_id (grant_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_master(input int i, input logic [AW-1:0] a, input logic d, input logic [DW-1:0] w);
    ma[i]   = a;
    mdir[i] = d;
    mdw[i]  = w;
  endtask

  task automatic drive_masters();
    for (int i = 0; i < N; i++) begin
      m_addr[i*AW +: AW]  = ma[i];
      m_wr_ni[i]          = mdir[i];
      m_dataW[i*DW +: DW] = mdw[i];
    end
    m_rq = pend;
  endtask

  // First pending master after the last one served, wrapping around
  function automatic int model_pick(input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      if (r[(model_last + k) % N]) return (model_last + k) % N;
    end
    return -1;
  endfunction

  // One complete transaction, entered and left at a negedge with the DUT idle
  task automatic run_txn(input logic [N-1:0] new_req, input int ack_dly, input int hold,
                         input bit tmo, input logic [DW-1:0] dv);
    int w;
    pend = pend | new_req;
    drive_masters();
    ack = 1'b0;
    w = model_pick(pend);
    tick();
    chk("rq_rise", 32'(rq), 32'd1);
    chk("grant_id", 32'(grant_id), 32'(w));
    chk("address", 32'(address), 32'(ma[w]));
    chk("wr_ni", 32'(wr_ni), 32'(mdir[w]));
    chk("dataW", 32'(dataW), 32'(mdw[w]));
    chk("busy_req", 32'(busy), 32'd1);
    if (!tmo) begin
      repeat (ack_dly) begin
        tick();
        chk("rq_wait", 32'(rq), 32'd1);
        chk("no_early_ack", 32'(m_ack), 32'd0);
      end
      ack   = 1'b1;
      dataR = dv;
      tick();
      model_dataR = dv;
      chk("m_ack_pulse", 32'(m_ack), 32'(1 << w));
      chk("m_err_clear", 32'(m_err), 32'd0);
      chk("m_dataR", 32'(m_dataR), 32'(model_dataR));
      chk("rq_fall", 32'(rq), 32'd0);
      pend[w] = 1'b0;
      m_rq    = pend;
      dataR   = DW'($urandom);
      repeat (hold) begin
        tick();
        chk("hold_ack_low", 32'(m_ack), 32'd0);
        chk("hold_rq_low", 32'(rq), 32'd0);
        chk("hold_busy", 32'(busy), 32'd1);
      end
      ack = 1'b0;
      tick();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_m_ack", 32'(m_ack), 32'd0);
      chk("idle_rq", 32'(rq), 32'd0);
      chk("addr_stable", 32'(address), 32'(ma[w]));
      chk("dataR_held", 32'(m_dataR), 32'(model_dataR));
    end else begin
      dataR = dv;
      repeat (TO - 1) begin
        tick();
        chk("tmo_rq_held", 32'(rq), 32'd1);
        chk("tmo_no_ack", 32'(m_ack), 32'd0);
      end
      tick();
      chk("tmo_m_ack", 32'(m_ack), 32'(1 << w));
      chk("tmo_m_err", 32'(m_err), 32'(1 << w));
      chk("tmo_rq_fall", 32'(rq), 32'd0);
      chk("tmo_dataR_kept", 32'(m_dataR), 32'(model_dataR));
      pend[w] = 1'b0;
      m_rq    = pend;
      tick();
      chk("tmo_idle_busy", 32'(busy), 32'd0);
      chk("tmo_err_pulse", 32'(m_err), 32'd0);
    end
    model_last = w;
  endtask

  task automatic chk_reset_values(input string pfx);
    chk({pfx, "_rq"}, 32'(rq), 32'd0);
    chk({pfx, "_address"}, 32'(address), 32'd0);
    chk({pfx, "_wr_ni"}, 32'(wr_ni), 32'(WR_NI_READ));
    chk({pfx, "_dataW"}, 32'(dataW), 32'd0);
    chk({pfx, "_m_ack"}, 32'(m_ack), 32'd0);
    chk({pfx, "_m_err"}, 32'(m_err), 32'd0);
    chk({pfx, "_m_dataR"}, 32'(m_dataR), 32'd0);
    chk({pfx, "_busy"}, 32'(busy), 32'd0);
    chk({pfx, "_grant_id"}, 32'(grant_id), 32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    ack         = 1'b0;
    dataR       = '0;
    m_rq        = '0;
    m_addr      = '0;
    m_wr_ni     = '0;
    m_dataW     = '0;
    pend        = '0;
    model_last  = N - 1;
    model_dataR = '0;
    for (int i = 0; i < N; i++) set_master(i, '0, WR_NI_READ, '0);

    @(negedge clk);
    chk_reset_values("rst");
    reset = 1'b0;

    // No requests: arbiter must stay idle
    repeat (3) tick();
    chk("noreq_busy", 32'(busy), 32'd0);
    chk("noreq_rq", 32'(rq), 32'd0);

    // Single read: master 2, ack three cycles after rq
    set_master(2, 4'h5, WR_NI_READ, 8'h00);
    run_txn(4'b0100, 2, 0, 1'b0, 8'hA7);

    // Single write: master 0
    set_master(0, 4'hC, WR_NI_WRITE, 8'h3C);
    run_txn(4'b0001, 1, 0, 1'b0, 8'h11);

    // Timeout: master 1, client never acknowledges
    set_master(1, 4'h9, WR_NI_READ, 8'h55);
    run_txn(4'b0010, 0, 0, 1'b1, 8'hEE);

    // Slow release with another master waiting
    set_master(1, 4'h2, WR_NI_WRITE, 8'h81);
    set_master(3, 4'hF, WR_NI_READ, 8'h42);
    run_txn(4'b1010, 0, 5, 1'b0, 8'h6E);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      nr = N'($urandom);
      if ((pend | nr) == '0) nr[$urandom_range(0, N - 1)] = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (nr[i] && !pend[i]) set_master(i, AW'($urandom), 1'($urandom), DW'($urandom));
      end
      run_txn(nr, $urandom_range(0, 6), $urandom_range(0, 3),
              ($urandom_range(0, 7) == 0), DW'($urandom));
    end

    // Reset while the client request is outstanding
    set_master(2, 4'h7, WR_NI_WRITE, 8'h99);
    pend = pend | 4'b0100;
    drive_masters();
    tick();
    chk("midop_rq_up", 32'(rq), 32'd1);
    reset = 1'b1;
    #1;
    chk_reset_values("midop");
    pend = '0;
    m_rq = '0;
    model_last  = N - 1;
    model_dataR = '0;
    tick();
    chk("midop_rq_held_low", 32'(rq), 32'd0);
    reset = 1'b0;

    // Fairness from reset: everyone keeps requesting, expect 0,1,2,3,0
    for (int i = 0; i < N; i++) set_master(i, AW'(i + 3), 1'(i), DW'(8'h10 * i + 1));
    for (int t = 0; t < 5; t++) begin
      run_txn(4'b1111, $urandom_range(0, 2), 0, 1'b0, DW'($urandom));
      chk("fair_order", 32'(model_last), 32'(t % N));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_bus_arbiter
`default_nettype wire
